// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main control FSM; sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, enables and the 2-bit aluOp consumed by aluCtr.
module mc_main_ctrl #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           memReady,
    output logic           pcWrite,
    output logic           pcWriteCond,
    output logic           pcWriteCondNe,
    output logic           iorD,
    output logic           memRead,
    output logic           memWrite,
    output logic           irWrite,
    output logic           memToReg,
    output logic           regDst,
    output logic           regWrite,
    output logic           aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     aluOp,
    output logic [1:0]     pcSource,
    output logic [STW-1:0] state
);
    typedef enum logic [STW-1:0] {
        S_FETCH  = STW'(0),
        S_DECODE = STW'(1),
        S_MEMADR = STW'(2),
        S_MEMRD  = STW'(3),
        S_MEMWB  = STW'(4),
        S_MEMWR  = STW'(5),
        S_EXEC   = STW'(6),
        S_RWB    = STW'(7),
        S_BRANCH = STW'(8),
        S_JUMP   = STW'(9),
        S_IEXEC  = STW'(10),
        S_IWB    = STW'(11)
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    state_t r_state, w_next;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next        = S_FETCH;
        pcWrite       = 1'b0;
        pcWriteCond   = 1'b0;
        pcWriteCondNe = 1'b0;
        iorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        memToReg      = 1'b0;
        regDst        = 1'b0;
        regWrite      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        aluOp         = 2'b00;
        pcSource      = 2'b00;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                w_next  = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                w_next  = (opcode == OP_LW || opcode == OP_SW)     ? S_MEMADR :
                          (opcode == OP_R)                         ? S_EXEC   :
                          (opcode == OP_BEQ || opcode == OP_BNE)   ? S_BRANCH :
                          (opcode == OP_J)                         ? S_JUMP   :
                          (opcode == OP_ADDI || opcode == OP_ANDI) ? S_IEXEC  : S_FETCH;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                w_next  = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                w_next   = memReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA       = 1'b1;
                aluOp         = 2'b01;
                pcSource      = 2'b01;
                pcWriteCond   = (opcode == OP_BEQ);
                pcWriteCondNe = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                w_next  = S_IWB;
            end
            S_IWB: regWrite = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // reset overrides every decoded output in the same cycle, not just from the next edge
        if (reset) begin
            pcWrite       = 1'b0;
            pcWriteCond   = 1'b0;
            pcWriteCondNe = 1'b0;
            iorD          = 1'b0;
            memRead       = 1'b0;
            memWrite      = 1'b0;
            irWrite       = 1'b0;
            memToReg      = 1'b0;
            regDst        = 1'b0;
            regWrite      = 1'b0;
            aluSrcA       = 1'b0;
            aluSrcB       = 2'b00;
            aluOp         = 2'b00;
            pcSource      = 2'b00;
        end
    end
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed per-cycle scoreboard for the multicycle main control FSM.
module tb_mc_main_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
    int         errors = 0;
    int         checks = 0;
    logic [20:0] sb_q[$];

    always #5 clk = ~clk;

    mc_main_ctrl #(.OPW(6), .STW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcWriteCondNe(pcWriteCondNe),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .state(state)
    );

    // Reference outputs, packed {pcWrite,pcWriteCond,pcWriteCondNe,iorD,memRead,memWrite,
    // irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource}
    function automatic logic [16:0] model(input logic [3:0] s, input logic [5:0] op,
                                          input logic mr, input logic rst);
        logic pw, pwc, pwn, io, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, pwc, pwn, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps} = '0;
        if (!rst) begin
            if (s == 4'd0) begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            else if (s == 4'd1) sb = 2'b11;
            else if (s == 4'd2) begin sa = 1; sb = 2'b10; end
            else if (s == 4'd3) begin mrd = 1; io = 1; end
            else if (s == 4'd4) begin rw = 1; m2r = 1; end
            else if (s == 4'd5) begin mwr = 1; io = 1; end
            else if (s == 4'd6) begin sa = 1; ao = 2'b10; end
            else if (s == 4'd7) begin rw = 1; rd = 1; end
            else if (s == 4'd8) begin
                sa = 1; ao = 2'b01; ps = 2'b01;
                pwc = (op == 6'b000100); pwn = (op == 6'b000101);
            end
            else if (s == 4'd9) begin pw = 1; ps = 2'b10; end
            else if (s == 4'd10) begin sa = 1; sb = 2'b10; ao = (op == 6'b001100) ? 2'b11 : 2'b00; end
            else if (s == 4'd11) rw = 1;
        end
        return {pw, pwc, pwn, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps};
    endfunction

    // One clock cycle: drive memReady, record expectation, compare, then advance past the edge.
    task automatic cyc(input logic [3:0] es, input logic mr);
        logic [20:0] exp_v;
        logic [16:0] obs_o;
        memReady = mr;
        #1;
        sb_q.push_back({es, model(es, opcode, mr, reset)});
        exp_v = sb_q.pop_front();
        obs_o = {pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite,
                 memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};
        checks++;
        assert (state === exp_v[20:17]) else begin
            errors++;
            $error("FAIL state t=%0t: observed %0d expected %0d", $time, state, exp_v[20:17]);
        end
        checks++;
        assert (obs_o === exp_v[16:0]) else begin
            errors++;
            $error("FAIL outputs st=%0d t=%0t: observed %b expected %b", exp_v[20:17], $time, obs_o, exp_v[16:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0);
        cyc(0, 1);
        reset = 0;
        // R-type, memReady high; DECODE/EXEC ignore memReady
        opcode = 6'b000000;
        cyc(0, 1); cyc(1, 0); cyc(6, 0); cyc(7, 1);
        // lw with fetch and memory waits
        opcode = 6'b100011;
        cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1);
        cyc(1, 0); cyc(2, 0); cyc(3, 0); cyc(3, 0); cyc(3, 1); cyc(4, 0);
        // beq then bne
        opcode = 6'b000100;
        cyc(0, 1); cyc(1, 1); cyc(8, 1);
        opcode = 6'b000101;
        cyc(0, 1); cyc(1, 1); cyc(8, 1);
        // addi, andi, j
        opcode = 6'b001000;
        cyc(0, 1); cyc(1, 1); cyc(10, 1); cyc(11, 1);
        opcode = 6'b001100;
        cyc(0, 1); cyc(1, 1); cyc(10, 1); cyc(11, 1);
        opcode = 6'b000010;
        cyc(0, 1); cyc(1, 1); cyc(9, 1);
        // illegal opcode is dropped after DECODE
        opcode = 6'b111111;
        cyc(0, 1); cyc(1, 1);
        // sw, immediate ready then with a write wait
        opcode = 6'b101011;
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(5, 1);
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(5, 0); cyc(5, 0); cyc(5, 1);
        // reset mid-MEMRD wait
        opcode = 6'b100011;
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 0);
        reset = 1;
        cyc(3, 0); cyc(0, 1);
        reset = 0;
        cyc(0, 0); cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 1); cyc(4, 1);
        cyc(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main control FSM. It is the producer side of the aluOp interface that aluCtr decodes.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives datapath mux selects, register, PC and memory enables, and the 2-bit aluOp.
- Sits between the instruction register opcode field and the shared multicycle datapath. Memory accesses use a ready handshake.

Parameters:
- OPW, 6, opcode width (instr[31:26])
- STW, 4, state register width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- memReady  input  1  memory completes the current access this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero=1 (beq)
- pcWriteCondNe  output  1  PC load if ALU zero=0 (bne)
- iorD  output  1  memory address select: 0=PC, 1=ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  instruction register load
- memToReg  output  1  register write data select: 0=ALUOut, 1=MDR
- regDst  output  1  destination register select: 0=rt, 1=rd
- regWrite  output  1  register file write enable
- aluSrcA  output  1  ALU A select: 0=PC, 1=A
- aluSrcB  output  2  ALU B select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
- aluOp  output  2  00=add, 01=sub, 10=use funct, 11=and (andi)
- pcSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- state  output  4  current state, for debug and bench

Behaviour:
- Opcodes:
  - R=000000, lw=100011, sw=101011, beq=000100, bne=000101
  - addi=001000, andi=001100, j=000010
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11
- Codes 12-15 are illegal states; they go to FETCH next cycle with all outputs 0.
- Reset:
  - reset=1 at a clock edge loads state=FETCH, regardless of current state, including mid-instruction or mid-memory wait.
  - While reset=1, every output except state is forced to 0, combinationally.
- Moore outputs: decoded from state only, except the memReady-qualified enables listed below. Every output not listed for a state is 0.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite =1 only in the cycle memReady=1.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute).
  - Next state by opcode:
    - lw/sw -> MEMADR
    - R -> EXEC
    - beq/bne -> BRANCH
    - j -> JUMP
    - addi/andi -> IEXEC
    - any other opcode -> FETCH (no architectural write; the instruction is dropped)
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: memRead=1, iorD=1. Wait for memReady, then go to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Next: FETCH.
- MEMWR:
  - memWrite=1, iorD=1; hold both while memReady=0.
  - Go to FETCH in the cycle memReady=1.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next: RWB.
- RWB: regWrite=1, regDst=1, memToReg=0. Next: FETCH.
- BRANCH:
  - aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01.
  - beq: pcWriteCond=1. bne: pcWriteCondNe=1.
  - Next: FETCH.
- JUMP: pcWrite=1, pcSource=10. Next: FETCH.
- IEXEC: aluSrcA=1, aluSrcB=10; aluOp=00 for addi, 11 for andi. Next: IWB.
- IWB: regWrite=1, regDst=0, memToReg=0. Next: FETCH.
- Opcode is sampled combinationally in DECODE, MEMADR, BRANCH and IEXEC. The datapath holds IR stable until the next FETCH with irWrite=1.
- memReady is ignored outside FETCH, MEMRD and MEMWR.
- CPI with memReady tied 1:
  - R=4, lw=5, sw=4, beq/bne=3, j=3, addi/andi=4, illegal opcode=2.
- Each memory wait cycle adds 1 to the instruction's cycle count.

Test Plan:
- Reset: hold reset 2 cycles from an arbitrary state, including mid-MEMRD wait -> state=0, all outputs 0 during reset, first cycle after release shows FETCH outputs.
- R-type (000000), memReady=1 -> state sequence 0,1,6,7,0; aluOp=10 in EXEC; regWrite=1 and regDst=1 only in RWB.
- lw (100011), memReady low for 3 cycles in FETCH and 2 cycles in MEMRD -> sequence 0,0,0,0,1,2,3,3,3,4,0; irWrite=1 only in the last FETCH cycle; memToReg=1 and regWrite=1 in MEMWB.
- beq (000100) then bne (000101) -> 0,1,8,0 each; aluOp=01, pcSource=01; pcWriteCond=1 only for beq, pcWriteCondNe=1 only for bne.
- addi (001000) vs andi (001100) -> 0,1,10,11,0; aluOp=00 vs 11 in IEXEC; j (000010) -> 0,1,9,0 with pcWrite=1, pcSource=10.
- Illegal opcode 111111 -> 0,1,0; no regWrite, memWrite or pcWrite asserted after FETCH; sw (101011) -> 0,1,2,5,0 with memWrite=1 only in MEMWR.
